dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-ported synchronous data memory.
- Port 0 is the LSU; port 1 is a secondary master (debug/DMA loader).
- Accepts one request at a time, round-robin between the ports, and drives the memory command.
- Screens misaligned or illegal accesses, then returns read data (or an error) with a one-cycle done pulse per port.

---
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer for the
// single-ported synchronous data memory, with alignment screening.
module dmem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [1:0]        rwtype0_i,
    input  logic [1:0]        rwtype1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_en_o,
    output logic              mem_wr_o,
    output logic [1:0]        mem_rwtype_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic              bad_q, bad_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              en_q, en_d;
    logic              wr_q, wr_d;
    logic [1:0]        rt_q, rt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic              win;
    logic              sel_we;
    logic [1:0]        sel_rt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wd;
    logic              sel_bad;

    // A tie goes to the port that was not granted last
    assign win      = (req_i == 2'b11) ? ~last_q : req_i[1];
    assign sel_we   = win ? we_i[1]   : we_i[0];
    assign sel_rt   = win ? rwtype1_i : rwtype0_i;
    assign sel_addr = win ? addr1_i   : addr0_i;
    assign sel_wd   = win ? wdata1_i  : wdata0_i;

    // Flag illegal size or misaligned address of the winning command
    always_comb begin
        sel_bad = 1'b1;
        case (sel_rt)
            2'b00:   sel_bad = 1'b0;
            2'b01:   sel_bad = sel_addr[0];
            2'b10:   sel_bad = |sel_addr[1:0];
            default: sel_bad = 1'b1;
        endcase
    end

    // Next state and registered outputs for the IDLE/ISSUE/RESP sequence
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        bad_d   = bad_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        en_d    = 1'b0;
        wr_d    = wr_q;
        rt_d    = rt_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = ISSUE;
                    last_d  = win;
                    win_d   = win;
                    bad_d   = sel_bad;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    en_d    = ~sel_bad;
                    wr_d    = sel_we;
                    rt_d    = sel_rt;
                    addr_d  = sel_addr;
                    wd_d    = sel_wd;
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                done_d  = win_q ? 2'b10 : 2'b01;
                err_d   = bad_q;
                rdata_d = (bad_q || wr_q) ? '0 : mem_rdata_i;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            bad_q   <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            rdata_q <= '0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            rt_q    <= 2'b10;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            bad_q   <= bad_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            rt_q    <= rt_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign rdata_o      = rdata_q;
    assign mem_en_o     = en_q;
    assign mem_wr_o     = wr_q;
    assign mem_rwtype_o = rt_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors, corner sequences and a randomized
// run against a transaction-level reference model.
module tb_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [1:0]  rwtype0_i, rwtype1_i;
    logic [11:0] addr0_i, addr1_i;
    logic [31:0] wdata0_i, wdata1_i;
    logic [1:0]  gnt_o, done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        mem_en_o, mem_wr_o;
    logic [1:0]  mem_rwtype_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'h0;

    always #5 clk_i = ~clk_i;

    dmem_arbiter dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .rwtype0_i    (rwtype0_i),
        .rwtype1_i    (rwtype1_i),
        .addr0_i      (addr0_i),
        .addr1_i      (addr1_i),
        .wdata0_i     (wdata0_i),
        .wdata1_i     (wdata1_i),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .mem_en_o     (mem_en_o),
        .mem_wr_o     (mem_wr_o),
        .mem_rwtype_o (mem_rwtype_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    // Word-wide behavioural memory; stores write the whole right-aligned word
    logic [31:0] mem [1024];
    bit          mem_init = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            1:       return 32'hCAFE0001;
            4:       return 32'hDEADBEEF;
            'h40:    return 32'h11112222;
            'h41:    return 32'h33334444;
            default: return (i * 32'h01000193) ^ 32'h5A5A0000;
        endcase
    endfunction

    always @(posedge clk_i) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
            mem_init = 1'b1;
        end
        if (mem_en_o && mem_wr_o) mem[mem_addr_o[11:2]] = mem_wdata_o;
        if (mem_en_o && !mem_wr_o) mem_rdata_i <= mem[mem_addr_o[11:2]];
        else mem_rdata_i <= $urandom;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_cmd(input int p, input logic we, input logic [1:0] rt,
                           input logic [11:0] a, input logic [31:0] wd);
        we_i[p] = we;
        if (p == 0) begin
            rwtype0_i = rt; addr0_i = a; wdata0_i = wd;
        end else begin
            rwtype1_i = rt; addr1_i = a; wdata1_i = wd;
        end
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        req_i  = 2'b00;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    function automatic bit legal(input logic [1:0] rt, input logic [11:0] a);
        int sz;
        if (rt == 2'b11) return 1'b0;
        sz = 1 << rt;
        return (int'(a) % sz) == 0;
    endfunction

    typedef struct {
        int          port;
        logic        we;
        logic [1:0]  rt;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        exp_en;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[7];

    // Reference model state
    int          busy;
    logic        last;
    logic        t_w, t_err;
    logic [31:0] t_rdata;
    logic [31:0] ref_mem [1024];
    logic [1:0]  e_gnt, e_done;
    logic        e_en, e_err, e_wr;
    logic [31:0] e_rdata, e_wd;
    logic [11:0] e_addr;
    logic [1:0]  e_rt;
    logic [1:0]  pend;
    int          en_cnt;

    task automatic model_step();
        logic        w, ok, we;
        logic [1:0]  rt;
        logic [11:0] a;
        logic [31:0] wd;
        e_gnt  = 2'b00;
        e_en   = 1'b0;
        e_done = 2'b00;
        if (busy == 0) begin
            if (req_i != 2'b00) begin
                w  = (req_i == 2'b11) ? !last : req_i[1];
                last = w;
                we = we_i[w];
                rt = w ? rwtype1_i : rwtype0_i;
                a  = w ? addr1_i : addr0_i;
                wd = w ? wdata1_i : wdata0_i;
                ok = legal(rt, a);
                e_gnt  = 2'b01 << w;
                e_en   = ok;
                e_wr   = we;
                e_rt   = rt;
                e_addr = a;
                e_wd   = wd;
                t_w    = w;
                t_err  = !ok;
                t_rdata = (ok && !we) ? ref_mem[a / 4] : 32'h0;
                if (ok && we) ref_mem[a / 4] = wd;
                busy = 2;
            end
        end else if (busy == 2) begin
            busy = 1;
        end else begin
            e_done  = 2'b01 << t_w;
            e_err   = t_err;
            e_rdata = t_rdata;
            busy    = 0;
        end
    endtask

    initial begin
        we_i = 2'b00;
        set_cmd(0, 1'b0, 2'b10, 12'h0, 32'h0);
        set_cmd(1, 1'b0, 2'b10, 12'h0, 32'h0);

        vt[0] = '{0, 1'b0, 2'b10, 12'h010, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF};
        vt[1] = '{1, 1'b1, 2'b00, 12'h003, 32'h000000A5, 1'b1, 1'b0, 32'h0};
        vt[2] = '{0, 1'b0, 2'b01, 12'h005, 32'h0, 1'b0, 1'b1, 32'h0};
        vt[3] = '{0, 1'b0, 2'b11, 12'h000, 32'h0, 1'b0, 1'b1, 32'h0};
        vt[4] = '{1, 1'b0, 2'b01, 12'h006, 32'h0, 1'b1, 1'b0, 32'hCAFE0001};
        vt[5] = '{0, 1'b0, 2'b10, 12'h012, 32'h0, 1'b0, 1'b1, 32'h0};
        vt[6] = '{1, 1'b1, 2'b10, 12'h101, 32'h12345678, 1'b0, 1'b1, 32'h0};

        rstn_i = 1'b0;
        req_i  = 2'b00;
        @(negedge clk_i);
        chk("rst gnt", 32'(gnt_o), 32'h0);
        chk("rst done", 32'(done_o), 32'h0);
        chk("rst err", 32'(err_o), 32'h0);
        chk("rst rdata", rdata_o, 32'h0);
        chk("rst en", 32'(mem_en_o), 32'h0);
        chk("rst wr", 32'(mem_wr_o), 32'h0);
        chk("rst rwtype", 32'(mem_rwtype_o), 32'h2);
        chk("rst addr", 32'(mem_addr_o), 32'h0);
        chk("rst wdata", mem_wdata_o, 32'h0);
        do_reset();

        // Directed single transactions
        for (int i = 0; i < 7; i++) begin
            set_cmd(vt[i].port, vt[i].we, vt[i].rt, vt[i].addr, vt[i].wd);
            req_i = 2'b01 << vt[i].port;
            @(negedge clk_i);
            chk($sformatf("v%0d gnt", i), 32'(gnt_o),
                32'(2'b01 << vt[i].port));
            chk($sformatf("v%0d en", i), 32'(mem_en_o), 32'(vt[i].exp_en));
            if (vt[i].exp_en) begin
                chk($sformatf("v%0d addr", i), 32'(mem_addr_o),
                    32'(vt[i].addr));
                chk($sformatf("v%0d wr", i), 32'(mem_wr_o), 32'(vt[i].we));
                chk($sformatf("v%0d rwtype", i), 32'(mem_rwtype_o),
                    32'(vt[i].rt));
                if (vt[i].we)
                    chk($sformatf("v%0d wdata", i), mem_wdata_o, vt[i].wd);
            end
            req_i = 2'b00;
            @(negedge clk_i);
            chk($sformatf("v%0d en2", i), 32'(mem_en_o), 32'h0);
            chk($sformatf("v%0d gnt2", i), 32'(gnt_o), 32'h0);
            chk($sformatf("v%0d done2", i), 32'(done_o), 32'h0);
            @(negedge clk_i);
            chk($sformatf("v%0d done", i), 32'(done_o),
                32'(2'b01 << vt[i].port));
            chk($sformatf("v%0d err", i), 32'(err_o), 32'(vt[i].exp_err));
            chk($sformatf("v%0d rdata", i), rdata_o, vt[i].exp_rd);
            @(negedge clk_i);
            chk($sformatf("v%0d done3", i), 32'(done_o), 32'h0);
        end

        // Both ports requesting continuously from reset
        do_reset();
        set_cmd(0, 1'b0, 2'b10, 12'h010, 32'h0);
        set_cmd(1, 1'b0, 2'b10, 12'h100, 32'h0);
        req_i  = 2'b11;
        en_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_i);
            chk($sformatf("rr gnt k%0d", k), 32'(gnt_o),
                (k % 3 != 1) ? 32'h0 : (((k / 3) % 2 == 1) ? 32'h2 : 32'h1));
            if (mem_en_o) en_cnt++;
        end
        chk("rr en pulses", 32'(en_cnt), 32'd4);
        req_i = 2'b00;
        repeat (3) @(negedge clk_i);

        // Lone port 1 back-to-back reads
        do_reset();
        set_cmd(1, 1'b0, 2'b10, 12'h100, 32'h0);
        req_i = 2'b10;
        @(negedge clk_i);
        chk("b2b gnt1", 32'(gnt_o), 32'h2);
        chk("b2b addr1", 32'(mem_addr_o), 32'h100);
        addr1_i = 12'h104;
        repeat (2) @(negedge clk_i);
        chk("b2b done1", 32'(done_o), 32'h2);
        chk("b2b rdata1", rdata_o, 32'h11112222);
        @(negedge clk_i);
        chk("b2b gnt2", 32'(gnt_o), 32'h2);
        chk("b2b addr2", 32'(mem_addr_o), 32'h104);
        req_i = 2'b00;
        repeat (2) @(negedge clk_i);
        chk("b2b done2", 32'(done_o), 32'h2);
        chk("b2b rdata2", rdata_o, 32'h33334444);

        // Reset asserted during the response cycle
        do_reset();
        set_cmd(0, 1'b0, 2'b10, 12'h010, 32'h0);
        req_i = 2'b01;
        @(negedge clk_i);
        chk("ar gnt", 32'(gnt_o), 32'h1);
        req_i = 2'b00;
        @(negedge clk_i);
        #1 rstn_i = 1'b0;
        #1;
        chk("ar gnt0", 32'(gnt_o), 32'h0);
        chk("ar en0", 32'(mem_en_o), 32'h0);
        chk("ar addr0", 32'(mem_addr_o), 32'h0);
        chk("ar rwtype", 32'(mem_rwtype_o), 32'h2);
        chk("ar done0", 32'(done_o), 32'h0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("ar done a", 32'(done_o), 32'h0);
        set_cmd(1, 1'b0, 2'b10, 12'h100, 32'h0);
        req_i = 2'b11;
        @(negedge clk_i);
        chk("ar done b", 32'(done_o), 32'h0);
        chk("ar tie gnt", 32'(gnt_o), 32'h1);
        req_i = 2'b00;
        repeat (3) @(negedge clk_i);

        // Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        busy = 0;
        last = 1'b1;
        pend = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_i);
            model_step();
            @(negedge clk_i);
            chk("rnd gnt", 32'(gnt_o), 32'(e_gnt));
            chk("rnd en", 32'(mem_en_o), 32'(e_en));
            chk("rnd done", 32'(done_o), 32'(e_done));
            if (e_en) begin
                chk("rnd addr", 32'(mem_addr_o), 32'(e_addr));
                chk("rnd wr", 32'(mem_wr_o), 32'(e_wr));
                chk("rnd rwtype", 32'(mem_rwtype_o), 32'(e_rt));
                if (e_wr) chk("rnd wdata", mem_wdata_o, e_wd);
            end
            if (e_done != 2'b00) begin
                chk("rnd err", 32'(err_o), 32'(e_err));
                chk("rnd rdata", rdata_o, e_rdata);
            end
            for (int p = 0; p < 2; p++) begin
                if (e_gnt[p]) pend[p] = 1'b0;
                if (!pend[p]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        logic [1:0]  rt;
                        logic [11:0] a;
                        rt = 2'($urandom_range(0, 3));
                        a  = 12'($urandom_range(0, 4095));
                        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                        set_cmd(p, 1'($urandom_range(0, 1)), rt, a, $urandom);
                        pend[p] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[p] = 1'b0;
                end
            end
            req_i = pend;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
